// File: rtl/req_arbiter_4.sv
// Four-requester arbiter (fixed priority or round-robin) with a hold limit and forced release.
// Latency: one cycle from sampled req to registered gnt; each release is followed by one idle cycle.
// Backpressure: the holder keeps the grant until done, request withdrawal, or the hold limit with others pending.
module req_arbiter_4 #(
    parameter int MODE_RR  = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    gnt_d;
    logic [1:0]    idx_d;
    logic          timeout_d;
    logic [1:0]    winner;
    logic [1:0]    cand;
    logic          rel_done, rel_drop, rel_hold;

    // Searching from the farthest candidate back to the nearest lets the nearest set bit win.
    always_comb begin
        winner = 2'b00;
        cand   = 2'b00;
        if (MODE_RR != 0) begin
            for (int k = 4; k >= 1; k--) begin
                cand = last_q + 2'(k);
                if (req[cand]) winner = cand;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) winner = 2'(i);
            end
        end
    end

    assign rel_done = done;
    assign rel_drop = ~req[gnt_idx];
    assign rel_hold = (cnt_q == HOLD_MAX) && (|(req & ~gnt));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gnt_d     = gnt;
        idx_d     = gnt_idx;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = 4'b0001 << winner;
                    idx_d   = winner;
                    cnt_d   = '0;
                    last_d  = winner;
                    state_d = BUSY;
                end else begin
                    gnt_d = 4'b0000;
                    idx_d = 2'b00;
                end
            end
            BUSY: begin
                if (rel_done || rel_drop || rel_hold) begin
                    gnt_d     = 4'b0000;
                    idx_d     = 2'b00;
                    state_d   = IDLE;
                    timeout_d = rel_hold && !rel_done && !rel_drop;
                end else if (cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                idx_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 2'b11;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'b00;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt       <= gnt_d;
            gnt_idx   <= idx_d;
            gnt_valid <= |gnt_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_req_arbiter_4.sv
// Drives a round-robin and a fixed-priority arbiter with shared stimulus and checks both against a cycle model.
module tb_req_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       vld_a, vld_b;
    logic       to_a, to_b;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = round-robin MAX_HOLD=3, index 1 = fixed priority MAX_HOLD=5
    int m_busy[2];
    int m_idx[2];
    int m_cnt[2];
    int m_last[2];
    int m_to[2];
    int p_mode[2];
    int p_max[2];

    req_arbiter_4 #(.MODE_RR(1), .MAX_HOLD(3)) dut_a (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a), .timeout(to_a)
    );

    req_arbiter_4 #(.MODE_RR(0), .MAX_HOLD(5)) dut_b (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b), .timeout(to_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int d, input logic [3:0] r);
        if (p_mode[d] != 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (r[(m_last[d] + k) % 4]) return (m_last[d] + k) % 4;
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end
        return 0;
    endfunction

    task automatic model_step(input int d);
        bit a, b, c;
        if (rst) begin
            m_busy[d] = 0; m_idx[d] = 0; m_cnt[d] = 0; m_last[d] = 3; m_to[d] = 0;
        end else if (m_busy[d] == 0) begin
            m_to[d] = 0;
            if (req != 4'b0000) begin
                m_idx[d]  = pick(d, req);
                m_last[d] = m_idx[d];
                m_busy[d] = 1;
                m_cnt[d]  = 0;
            end
        end else begin
            a = done;
            b = !req[m_idx[d]];
            c = (m_cnt[d] == p_max[d]) && ((req & ~(4'b0001 << m_idx[d])) != 4'b0000);
            if (a || b || c) begin
                m_busy[d] = 0;
                m_to[d]   = (c && !a && !b) ? 1 : 0;
                m_idx[d]  = 0;
            end else begin
                m_to[d]  = 0;
                m_cnt[d] = (m_cnt[d] + 1 > p_max[d]) ? p_max[d] : m_cnt[d] + 1;
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int d);
        return (m_busy[d] != 0) ? (4'b0001 << m_idx[d]) : 4'b0000;
    endfunction

    task automatic compare_all();
        chk("a_gnt", gnt_a, exp_gnt(0));
        chk("a_idx", {2'b00, idx_a}, 4'((m_busy[0] != 0) ? m_idx[0] : 0));
        chk("a_valid", {3'b000, vld_a}, 4'(m_busy[0]));
        chk("a_timeout", {3'b000, to_a}, 4'(m_to[0]));
        chk("b_gnt", gnt_b, exp_gnt(1));
        chk("b_idx", {2'b00, idx_b}, 4'((m_busy[1] != 0) ? m_idx[1] : 0));
        chk("b_valid", {3'b000, vld_b}, 4'(m_busy[1]));
        chk("b_timeout", {3'b000, to_b}, 4'(m_to[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        p_mode[0] = 1; p_max[0] = 3;
        p_mode[1] = 0; p_max[1] = 5;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_idx[d] = 0; m_cnt[d] = 0; m_last[d] = 3; m_to[d] = 0;
        end
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        #1;

        // reset and idle
        do_reset();
        chk("reset_gnt", gnt_a, 4'b0000);
        chk("reset_timeout", {3'b000, to_a}, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_gnt", gnt_a | gnt_b, 4'b0000);
        end

        // round-robin rotation with done two cycles after each grant
        do_reset();
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            chk("rr_seq_idx", {2'b00, idx_a}, 4'(g % 4));
            chk("fp_all_gnt", gnt_b, 4'b1000);
            tick();
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("rr_gap", gnt_a | gnt_b, 4'b0000);
            tick();
        end

        // fixed priority starves requester 0 while bit 2 is set
        do_reset();
        req = 4'b0101;
        tick();
        for (int g = 0; g < 4; g++) begin
            chk("fp_gnt", gnt_b, 4'b0100);
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            tick();
        end

        // forced release after the hold limit
        do_reset();
        req = 4'b0011;
        tick();
        chk("hold_first", gnt_a, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_kept", gnt_a, 4'b0001);
            chk("hold_no_to", {3'b000, to_a}, 4'b0000);
        end
        tick();
        chk("hold_release", gnt_a, 4'b0000);
        chk("hold_timeout", {3'b000, to_a}, 4'b0001);
        tick();
        chk("hold_next", gnt_a, 4'b0010);
        chk("hold_to_clear", {3'b000, to_a}, 4'b0000);
        for (int i = 0; i < 12; i++) tick();

        // sole requester keeps the grant with no timeout
        do_reset();
        req = 4'b0100;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("sole_gnt", gnt_a, 4'b0100);
            chk("sole_no_to", {3'b000, to_a}, 4'b0000);
        end
        req = 4'b0000;
        tick();
        chk("sole_drop", gnt_a, 4'b0000);
        chk("sole_drop_to", {3'b000, to_a}, 4'b0000);

        // reset mid-grant together with done
        do_reset();
        req = 4'b0010;
        tick();
        chk("mid_grant", gnt_a, 4'b0010);
        rst = 1'b1; done = 1'b1;
        tick();
        chk("mid_rst_gnt", gnt_a | gnt_b, 4'b0000);
        chk("mid_rst_to", {3'b000, to_a | to_b}, 4'b0000);
        rst = 1'b0; done = 1'b0;
        tick();
        chk("mid_regrant", gnt_a, 4'b0010);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) != 0) req = 4'($urandom);
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_arbiter_4.md
Name: req_arbiter_4

Overview:
- Four-requester arbiter for one shared downstream resource.
- Uses the same 4-to-2 index encoding as the priority encoder:
  - req[0] maps to index 2'b00.
  - req[3] maps to index 2'b11.
- Outputs a registered one-hot grant, an encoded grant index and a valid flag.
- Supports fixed-priority or round-robin selection, a per-grant hold limit with forced release, and a done handshake.

Parameters:
- MODE_RR, 1: 1 = round-robin arbitration; 0 = fixed priority (req[3] highest, req[0] lowest).
- MAX_HOLD, 8: maximum cycles a grant is held while other requests pend; range 1..255.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = requester i.
- done  input  1  current grant holder releases the resource; single-cycle pulse.
- gnt  output  4  one-hot grant, registered.
- gnt_idx  output  2  encoded index of the granted requester, registered.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0.
  - state=IDLE, hold counter=0, last_idx=2'b11, so the first round-robin search starts at requester 0.
- Reset asserted mid-grant takes effect at that edge; no further grant or timeout is produced.
- Invariants:
  - gnt_valid = (gnt != 0).
  - gnt is always zero or one-hot.
  - gnt_idx equals the encoded gnt when valid and holds 2'b00 when not valid.
- FSM, two states:
  - IDLE: if req != 0, select a winner, load gnt/gnt_idx, set gnt_valid=1, clear the hold counter, set last_idx=winner, go to BUSY. If req == 0, stay in IDLE with outputs zero.
  - BUSY: hold gnt stable. Increment the hold counter each cycle, saturating at MAX_HOLD.
- Release conditions in BUSY, checked every cycle; any one causes release at the next edge (gnt=0, gnt_valid=0, gnt_idx=0, go to IDLE):
  - (a) done=1.
  - (b) req[gnt_idx]=0, i.e. the holder withdrew its request.
  - (c) hold counter == MAX_HOLD and req has any bit set other than gnt_idx.
- Timeout pulse:
  - timeout=1 for exactly one cycle, coincident with the cleared grant, only when release is caused by (c) and neither (a) nor (b) is true that cycle.
  - If the counter is saturated and no other request pends, the grant is kept indefinitely with no timeout.
- Latency:
  - A grant appears on the edge after the request is sampled in IDLE, so 1 cycle from req to gnt.
  - Every release is followed by exactly one IDLE cycle with gnt=0 before the next grant. Back-to-back grants are therefore separated by a 1-cycle gap.
- Winner selection (combinational, from req sampled in IDLE):
  - MODE_RR=0: highest set index wins.
  - MODE_RR=1: search indices last_idx+1, last_idx+2, last_idx+3, last_idx (mod 4); the first set bit wins. The last holder therefore wins again only if it is the sole requester.
- Width rules:
  - The hold counter is wide enough for MAX_HOLD; the increment saturates and never wraps.
  - The last_idx addition is 2-bit modulo-4 arithmetic and wraps 3 to 0.
- Edge cases:
  - done in IDLE is ignored.
  - req changes in BUSY for non-holder bits do not affect gnt.
  - X/Z on req is not supported.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0 throughout.
- MODE_RR=1, req=4'b1111 held, done pulsed 2 cycles after each grant:
  - gnt_idx sequence is 0,1,2,3,0.
  - Each grant is followed by exactly one gnt=0 cycle.
- MODE_RR=0, req=4'b0101 held, done pulsed after each grant: every grant is gnt_idx=2 (gnt=4'b0100). Requester 0 is never granted while bit 2 stays set.
- MAX_HOLD=3, req=4'b0011 held, no done:
  - Grant idx0 is force-released after 3 counted cycles, with timeout=1 for one cycle.
  - One cycle later gnt=4'b0010 (round-robin).
- MAX_HOLD=3, req=4'b0100 only, no done for 20 cycles: gnt=4'b0100 stays, timeout never asserts. Then drop req[2]: gnt=0 on the next edge with no timeout.
- Grant active on idx1, assert rst for 1 cycle together with done=1: all outputs zero on that edge and no timeout. With req=4'b0010 still high, regrant occurs on the edge after rst is deasserted.
